// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

  // Sequencer states; CLEAR..CAPT repeat once per phase (A then B).
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_CAPT   = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Seed substituted for an all-zero challenge, which would lock the LFSR.
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One RO configuration: stage select in the upper half, bypass in the lower.
  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] bx;
  } ro_cfg_t;

  // Advance the LFSR one step: shift left, XOR of the taps enters bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_phase_timer.sv
// Down-counter that times the CLEAR/RUN/SETTLE phases of the sequencer.
// Loading L makes expire pulse on the L-th cycle after the load.
module puf_phase_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared so no phase is running out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: expands a 16-bit challenge with an LFSR into
// RO configuration pairs, times each measurement window exactly, and builds
// one response bit per pair from the two captured edge counts.
// Optional build macro PUF_TIE_MASK_EN adds the resp_tie output.
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1000,
  parameter int SETTLE    = 4
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [15:0]          req_challenge,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 busy,
  output logic                 ro_en,
  output logic [2:0]           ro_sel,
  output logic [2:0]           ro_bx,
  output logic                 cnt_clr,
  input  logic [CNT_W-1:0]     ro_count
`ifdef PUF_TIE_MASK_EN
  ,
  output logic [RESP_BITS-1:0] resp_tie
`endif
);

  localparam int TMAX  = (WINDOW > SETTLE) ? ((WINDOW > 2) ? WINDOW : 2)
                                           : ((SETTLE > 2) ? SETTLE : 2);
  localparam int TW    = $clog2(TMAX + 1);
  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 phase_b_q, phase_b_d;
  logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
  logic [RESP_BITS-1:0] resp_data_q, resp_data_d;
`ifdef PUF_TIE_MASK_EN
  logic [RESP_BITS-1:0] tie_q, tie_d;
`endif

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expire;
  ro_cfg_t       cfg_a, cfg_b, cfg_cur;
  logic          in_meas;

  puf_phase_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Derive the A/B configurations from the current LFSR; B is nudged when it collides with A.
  always_comb begin
    cfg_a = ro_cfg_t'(lfsr_q[5:0]);
    cfg_b = ro_cfg_t'(lfsr_q[11:6]);
    if (cfg_b == cfg_a) begin
      cfg_b.bx = cfg_b.bx ^ 3'b001;
    end
    cfg_cur = phase_b_q ? cfg_b : cfg_a;
  end

  // Next-state and datapath updates; each timed phase loads the timer on entry.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    phase_b_d   = phase_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    resp_data_d = resp_data_q;
`ifdef PUF_TIE_MASK_EN
    tie_d       = tie_q;
`endif
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lfsr_d      = (req_challenge == 16'h0000) ? LFSR_SEED_DEFAULT : req_challenge;
          idx_d       = '0;
          phase_b_d   = 1'b0;
          resp_data_d = '0;
`ifdef PUF_TIE_MASK_EN
          tie_d       = '0;
`endif
          tmr_load    = 1'b1;
          tmr_val     = TW'(2);
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(WINDOW);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_expire) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (phase_b_q) begin
          cnt_b_d = ro_count;
          state_d = S_NEXT;
        end else begin
          cnt_a_d   = ro_count;
          phase_b_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TW'(2);
          state_d   = S_CLEAR;
        end
      end
      S_NEXT: begin
        resp_data_d[idx_q] = (cnt_b_q > cnt_a_q);
`ifdef PUF_TIE_MASK_EN
        tie_d[idx_q]       = (cnt_b_q == cnt_a_q);
`endif
        lfsr_d = lfsr_next(lfsr_q);
        if (idx_q == IDX_W'(RESP_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + 1'b1;
          phase_b_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = TW'(2);
          state_d   = S_CLEAR;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any measurement in progress.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      idx_q       <= '0;
      phase_b_q   <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      resp_data_q <= '0;
`ifdef PUF_TIE_MASK_EN
      tie_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      phase_b_q   <= phase_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      resp_data_q <= resp_data_d;
`ifdef PUF_TIE_MASK_EN
      tie_q       <= tie_d;
`endif
    end
  end

  // Output decode from state; configuration is only presented while measuring.
  always_comb begin
    in_meas    = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                 (state_q == S_SETTLE) || (state_q == S_CAPT);
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_DONE);
    ro_en      = (state_q == S_RUN);
    cnt_clr    = (state_q == S_CLEAR);
    ro_sel     = 3'b000;
    ro_bx      = 3'b000;
    if (in_meas) begin
      ro_sel = cfg_cur.sel;
      ro_bx  = cfg_cur.bx;
    end
  end

  assign resp_data = resp_data_q;
`ifdef PUF_TIE_MASK_EN
  assign resp_tie  = tie_q;
`endif

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Self-checking bench for ro_puf_sequencer with a rate-based RO counter model.
module tb_ro_puf_sequencer;

  localparam int RESP_BITS = 8;
  localparam int CNT_W     = 16;
  localparam int WINDOW    = 16;
  localparam int SETTLE    = 4;
  localparam int LATENCY   = RESP_BITS * (2 * (3 + WINDOW + SETTLE) + 1) + 1;
  localparam int BUDGET    = LATENCY + 50;

  logic                 CLK;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [15:0]          req_challenge;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [RESP_BITS-1:0] resp_data;
  logic                 busy;
  logic                 ro_en;
  logic [2:0]           ro_sel;
  logic [2:0]           ro_bx;
  logic                 cnt_clr;
  logic [CNT_W-1:0]     ro_count;
`ifdef PUF_TIE_MASK_EN
  logic [RESP_BITS-1:0] resp_tie;
`endif

  int          chk_cnt;
  int          pass_cnt;
  int          violations;
  int unsigned rate [64];
  logic [5:0]  cfg_q [$];
  logic        prev_en;
  logic [5:0]  prev_cfg;

  logic [5:0]           exp_cfg [2*RESP_BITS];
  logic [RESP_BITS-1:0] exp_resp;
  logic [RESP_BITS-1:0] exp_tie;

  ro_puf_sequencer #(
    .RESP_BITS (RESP_BITS),
    .CNT_W     (CNT_W),
    .WINDOW    (WINDOW),
    .SETTLE    (SETTLE)
  ) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .busy          (busy),
    .ro_en         (ro_en),
    .ro_sel        (ro_sel),
    .ro_bx         (ro_bx),
    .cnt_clr       (cnt_clr),
    .ro_count      (ro_count)
`ifdef PUF_TIE_MASK_EN
    ,
    .resp_tie      (resp_tie)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RO edge counter model: each enabled cycle adds the configuration's rate, saturating.
  always @(negedge CLK) begin
    if (cnt_clr) begin
      ro_count <= '0;
    end else if (ro_en) begin
      if (32'(ro_count) + rate[{ro_sel, ro_bx}] > 32'h0000FFFF) ro_count <= 16'hFFFF;
      else ro_count <= ro_count + 16'(rate[{ro_sel, ro_bx}]);
    end
  end

  // Protocol monitor: record each measured configuration and flag illegal overlaps.
  always @(negedge CLK) begin
    if (ro_en && !prev_en) cfg_q.push_back({ro_sel, ro_bx});
    if ((ro_en && prev_en && ({ro_sel, ro_bx} !== prev_cfg)) || (ro_en && cnt_clr))
      violations <= violations + 1;
    prev_en  <= ro_en;
    prev_cfg <= {ro_sel, ro_bx};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: one response bit per pair, counts are window length times rate.
  task automatic modelRun(input logic [15:0] ch);
    logic [15:0] s;
    logic [5:0]  a, b;
    int unsigned ca, cb;
    s = (ch == 16'h0000) ? 16'hACE1 : ch;
    for (int i = 0; i < RESP_BITS; i++) begin
      a = s[5:0];
      b = s[11:6];
      if (b == a) b = b ^ 6'h01;
      ca = WINDOW * rate[a];
      cb = WINDOW * rate[b];
      if (ca > 65535) ca = 65535;
      if (cb > 65535) cb = 65535;
      exp_resp[i]    = (cb > ca);
      exp_tie[i]     = (cb == ca);
      exp_cfg[2*i]   = a;
      exp_cfg[2*i+1] = b;
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ch);
    @(negedge CLK);
    checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid     = 1'b1;
    req_challenge = ch;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    @(negedge CLK);
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    checkOutput("req_ready_after_handshake", {31'd0, req_ready}, 32'd1);
    checkOutput("resp_valid_after_handshake", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic runTxn(input string tag, input logic [15:0] ch, input bit do_hs);
    int cycles;
    cfg_q.delete();
    modelRun(ch);
    applyStimulus(ch);
    cycles = 1;
    while (resp_valid !== 1'b1 && cycles < BUDGET) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, LATENCY);
    checkOutput({tag, "_resp_data"}, {24'd0, resp_data}, {24'd0, exp_resp});
`ifdef PUF_TIE_MASK_EN
    checkOutput({tag, "_resp_tie"}, {24'd0, resp_tie}, {24'd0, exp_tie});
`endif
    checkOutput({tag, "_cfg_count"}, cfg_q.size(), 2 * RESP_BITS);
    for (int i = 0; i < 2 * RESP_BITS; i++) begin
      if (i < cfg_q.size())
        checkOutput($sformatf("%s_cfg%0d", tag, i), {26'd0, cfg_q[i]}, {26'd0, exp_cfg[i]});
    end
    if (do_hs) handshake();
  endtask

  initial begin
    logic [RESP_BITS-1:0] held;
    int                   drops;
    int                   waited;
    chk_cnt       = 0;
    pass_cnt      = 0;
    violations    = 0;
    prev_en       = 1'b0;
    prev_cfg      = '0;
    ro_count      = '0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_challenge = '0;
    resp_ready    = 1'b0;
    for (int i = 0; i < 64; i++) rate[i] = 10;

    #3;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_ro_en_clr", {30'd0, ro_en, cnt_clr}, 32'd0);
    checkOutput("rst_cfg", {26'd0, ro_sel, ro_bx}, 32'd0);
    checkOutput("rst_resp_data", {24'd0, resp_data}, 32'd0);
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;

    $display("[TB] challenge 0001, random rates");
    for (int i = 0; i < 64; i++) rate[i] = $urandom_range(1, 200);
    runTxn("ch0001", 16'h0001, 1'b1);

    $display("[TB] challenge 0000 uses default seed");
    for (int i = 0; i < 64; i++) rate[i] = $urandom_range(1, 200);
    runTxn("ch0000", 16'h0000, 1'b1);
    checkOutput("seed_first_A", {26'd0, cfg_q[0]}, 32'h21);
    checkOutput("seed_first_B", {26'd0, cfg_q[1]}, 32'h33);

    $display("[TB] equal rates give all-zero response");
    for (int i = 0; i < 64; i++) rate[i] = 37;
    runTxn("equal", 16'($urandom), 1'b1);
    checkOutput("equal_resp_zero", {24'd0, resp_data}, 32'd0);

    $display("[TB] saturating counts compared as-is");
    for (int i = 0; i < 64; i++) rate[i] = ($urandom_range(0, 1) == 1) ? 5000 : $urandom_range(1, 4000);
    runTxn("sat", 16'($urandom), 1'b1);

    $display("[TB] response held in DONE, busy request ignored");
    for (int i = 0; i < 64; i++) rate[i] = $urandom_range(1, 300);
    runTxn("hold", 16'($urandom), 1'b0);
    held  = resp_data;
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      req_valid     = (i == 10);
      req_challenge = 16'h1234;
      if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0) drops++;
    end
    @(negedge CLK);
    req_valid = 1'b0;
    checkOutput("hold_no_drop", drops, 0);
    checkOutput("hold_resp_data", {24'd0, resp_data}, {24'd0, exp_resp});
    checkOutput("hold_busy", {31'd0, busy}, 32'd1);
    handshake();
    checkOutput("hold_request_not_queued", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 64; i++) rate[i] = $urandom_range(1, 300);
    runTxn("after_hold", 16'($urandom), 1'b1);

    $display("[TB] reset in the middle of RUN");
    applyStimulus(16'($urandom));
    waited = 0;
    while (ro_en !== 1'b1 && waited < 20) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    checkOutput("midrun_reached_run", {31'd0, ro_en}, 32'd1);
    repeat (5) @(posedge CLK);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_ro_en_drop", {31'd0, ro_en}, 32'd0);
    checkOutput("midrun_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrun_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("midrun_resp_data", {24'd0, resp_data}, 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("midrun_post_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrun_post_resp_valid", {31'd0, resp_valid}, 32'd0);

    $display("[TB] random transactions");
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 64; i++) rate[i] = $urandom_range(1, 500);
      runTxn($sformatf("rand%0d", t), 16'($urandom), 1'b1);
    end

    @(negedge CLK);
    checkOutput("protocol_violations", violations, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
